// File: rtl/pkt_fifo_drain_if.sv
// Bundle between the drain stage, its upstream FWFT FIFO and the downstream module port.
// Handshake: FIFO head is valid while !in_fifo_empty and leaves the FIFO on a cycle with
// in_fifo_rd_en=1; out_wr carries one word per cycle and is only issued when out_rdy was high.
interface pkt_fifo_drain_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_fifo_dout;
  logic                             in_fifo_empty;
  logic                             in_fifo_rd_en;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;

  modport master (
    output in_fifo_dout, in_fifo_empty, out_rdy,
    input  in_fifo_rd_en, out_data, out_ctrl, out_wr
  );

  modport slave (
    input  in_fifo_dout, in_fifo_empty, out_rdy,
    output in_fifo_rd_en, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/pkt_fifo_drain.sv
// Packet-aware drain: pops a FWFT FIFO, forwards words with one cycle of latency,
// stops only at packet boundaries, and keeps packet/word statistics plus an oversize flag.
module pkt_fifo_drain #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 32,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  pkt_fifo_drain_if.slave        bus,
  input  logic                   enable,
  output logic                   in_pkt,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   oversize_err,
  output logic [1:0]             dbg_state
);

  localparam int PW_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [PW_W-1:0] PW_MAX = PW_W'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [PW_W-1:0]          r_pw;
  logic [PW_W-1:0]          w_next_pw;
  logic                     r_out_wr;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic [CTRL_WIDTH-1:0]    r_out_ctrl;
  logic [COUNT_WIDTH-1:0]   r_pkt_count;
  logic [COUNT_WIDTH-1:0]   r_word_count;
  logic                     r_oversize_err;

  logic                     w_pop;
  logic                     w_pkt_done;
  logic                     w_oversize;
  logic [CTRL_WIDTH-1:0]    w_ctrl;
  logic [DATA_WIDTH-1:0]    w_data;

  assign w_ctrl = bus.in_fifo_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign w_data = bus.in_fifo_dout[DATA_WIDTH-1:0];

  // enable only gates the start of a packet; an open packet always drains
  assign w_pop = !reset && !bus.in_fifo_empty && bus.out_rdy &&
                 ((r_state != S_IDLE) || enable);

  always_comb begin
    w_next_state = r_state;
    w_next_pw    = r_pw;
    w_pkt_done   = 1'b0;
    w_oversize   = 1'b0;
    if (w_pop) begin
      case (r_state)
        S_IDLE, S_HDR: begin
          if (w_ctrl != '0) begin
            w_next_state = S_HDR;
          end else begin
            w_next_state = S_PAYLOAD;
            w_next_pw    = PW_W'(1);
          end
        end
        S_PAYLOAD: begin
          if (r_pw == PW_MAX) w_oversize = 1'b1;
          if (w_ctrl != '0) begin
            w_next_state = S_IDLE;
            w_next_pw    = '0;
            w_pkt_done   = 1'b1;
          end else if (r_pw != PW_MAX) begin
            w_next_pw = r_pw + PW_W'(1);
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_pw    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pw           <= '0;
      r_out_wr       <= 1'b0;
      r_out_data     <= '0;
      r_out_ctrl     <= '0;
      r_pkt_count    <= '0;
      r_word_count   <= '0;
      r_oversize_err <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pw     <= w_next_pw;
      r_out_wr <= w_pop;
      if (w_pop) begin
        r_out_data   <= w_data;
        r_out_ctrl   <= w_ctrl;
        r_word_count <= r_word_count + COUNT_WIDTH'(1);
      end
      if (w_pkt_done) r_pkt_count    <= r_pkt_count + COUNT_WIDTH'(1);
      if (w_oversize) r_oversize_err <= 1'b1;
    end
  end

  assign bus.in_fifo_rd_en = w_pop;
  assign bus.out_wr        = r_out_wr;
  assign bus.out_data      = r_out_data;
  assign bus.out_ctrl      = r_out_ctrl;
  assign in_pkt            = (r_state != S_IDLE);
  assign pkt_count         = r_pkt_count;
  assign word_count        = r_word_count;
  assign oversize_err      = r_oversize_err;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_pkt_fifo_drain.sv
// Bench for pkt_fifo_drain: queue-based FIFO, packet-level reference model,
// directed scenarios followed by a randomized soak.
module tb_pkt_fifo_drain;
  localparam int DW   = 64;
  localparam int CW   = 8;
  localparam int NW   = DW + CW;
  localparam int MAXW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable;
  logic        in_pkt;
  logic [31:0] pkt_count;
  logic [31:0] word_count;
  logic        oversize_err;
  logic [1:0]  dbg_state;

  pkt_fifo_drain_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  pkt_fifo_drain #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .COUNT_WIDTH(32), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .enable(enable), .in_pkt(in_pkt),
    .pkt_count(pkt_count), .word_count(word_count),
    .oversize_err(oversize_err), .dbg_state(dbg_state)
  );

  logic [NW-1:0] fifo_q[$];
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] pend_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit tb_rdy, tb_en, tb_rst;

  // reference model: packet-level view (open packet, payload-phase words seen)
  bit          m_in_pkt;
  int          m_k;
  int unsigned m_pkts, m_words;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 0; m_k = 0; m_pkts = 0; m_words = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_pop(input logic [NW-1:0] w);
    logic [CW-1:0] c;
    c = w[NW-1:DW];
    m_words++;
    exp_q.push_back(w);
    if (!m_in_pkt || m_k == 0) begin
      m_in_pkt = 1;
      m_k = (c == '0) ? 1 : 0;
    end else begin
      m_k++;
      if (m_k > MAXW) m_err = 1;
      if (c != '0) begin
        m_pkts++;
        m_in_pkt = 0;
        m_k = 0;
      end
    end
  endtask

  // driver: one clock cycle, entered and left at a negedge
  task automatic cycle();
    logic exp_rd;
    logic popped;
    logic [NW-1:0] w;
    bus.in_fifo_empty = (fifo_q.size() == 0);
    bus.in_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    bus.out_rdy       = tb_rdy;
    enable            = tb_en;
    reset             = tb_rst;
    #1;
    exp_rd = !tb_rst && (fifo_q.size() != 0) && tb_rdy && (m_in_pkt || tb_en);
    check_eq("rd_en", bus.in_fifo_rd_en, exp_rd);
    popped = bus.in_fifo_rd_en && (fifo_q.size() != 0);
    @(posedge clk);
    w = '0;
    if (popped) w = fifo_q.pop_front();
    if (tb_rst) model_reset();
    else if (popped) model_pop(w);
    @(negedge clk);
    check_eq("out_wr", bus.out_wr, exp_q.size() != 0);
    if (bus.out_wr && exp_q.size() != 0)
      check_eq("out_word", {bus.out_ctrl, bus.out_data}, exp_q[0]);
    exp_q.delete();
    check_eq("in_pkt", in_pkt, m_in_pkt);
    check_eq("pkt_count", pkt_count, m_pkts);
    check_eq("word_count", word_count, m_words);
    check_eq("oversize_err", oversize_err, m_err);
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    fifo_q.push_back({c, d});
  endtask

  task automatic do_reset();
    tb_rst = 1;
    cycle();
    tb_rst = 0;
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_word_count", word_count, 0);
    check_eq("rst_in_pkt", in_pkt, 0);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (fifo_q.size() != 0 && i < budget) begin
      cycle();
      i++;
    end
    cycle();
    check_eq("drain_done", fifo_q.size(), 0);
  endtask

  task automatic gen_packet();
    int nh, np;
    nh = $urandom_range(0, 2);
    np = $urandom_range(0, 6);
    for (int i = 0; i < nh; i++)
      pend_q.push_back({CW'($urandom_range(1, 255)), {$urandom, $urandom}});
    for (int i = 0; i < np; i++)
      pend_q.push_back({CW'(0), {$urandom, $urandom}});
    pend_q.push_back({CW'($urandom_range(1, 255)), {$urandom, $urandom}});
  endtask

  initial begin
    tb_rdy = 1; tb_en = 1; tb_rst = 1;
    reset = 1; enable = 0;
    bus.in_fifo_empty = 1; bus.in_fifo_dout = '0; bus.out_rdy = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // basic 3-word packet
    push(8'hFF, 64'h1111_2222_3333_4444);
    push(8'h00, 64'hD0D0_D0D0_0000_0001);
    push(8'h01, 64'hD1D1_D1D1_0000_0002);
    drain(20);
    check_eq("t1_pkts", pkt_count, 1);
    check_eq("t1_words", word_count, 3);
    check_eq("t1_in_pkt", in_pkt, 0);

    // out_rdy toggling
    do_reset();
    push(8'hFF, 64'hAAAA); push(8'h00, 64'hBBBB); push(8'h01, 64'hCCCC);
    for (int i = 0; i < 8; i++) begin
      tb_rdy = (i % 2 == 0);
      cycle();
    end
    tb_rdy = 1;
    cycle();
    check_eq("t2_pkts", pkt_count, 1);
    check_eq("t2_words", word_count, 3);

    // enable dropped after header; second packet must wait
    do_reset();
    push(8'h10, 64'h1); push(8'h00, 64'h2); push(8'h00, 64'h3); push(8'h02, 64'h4);
    push(8'h20, 64'h5); push(8'h00, 64'h6); push(8'h03, 64'h7);
    cycle();
    tb_en = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("t3_held_words", fifo_q.size(), 3);
    check_eq("t3_in_pkt", in_pkt, 0);
    check_eq("t3_pkts1", pkt_count, 1);
    tb_en = 1;
    drain(20);
    check_eq("t3_pkts2", pkt_count, 2);

    // oversize: 1 header + 5 payload + EOP with a limit of 4
    do_reset();
    push(8'h40, 64'hE0);
    for (int i = 0; i < 5; i++) push(8'h00, 64'hE1 + 64'(i));
    push(8'h04, 64'hEF);
    for (int i = 0; i < 5; i++) cycle();
    check_eq("t4_err_before", oversize_err, 0);
    cycle();
    check_eq("t4_err_rise", oversize_err, 1);
    drain(20);
    check_eq("t4_words", word_count, 7);
    push(8'h40, 64'h1); push(8'h00, 64'h2); push(8'h05, 64'h3);
    drain(20);
    check_eq("t4_err_sticky", oversize_err, 1);
    check_eq("t4_pkts", pkt_count, 2);
    do_reset();
    check_eq("t4_err_cleared", oversize_err, 0);

    // FIFO gap mid-payload
    push(8'h50, 64'h10); push(8'h00, 64'h11); push(8'h00, 64'h12);
    drain(20);
    for (int i = 0; i < 10; i++) cycle();
    check_eq("t5_in_pkt_gap", in_pkt, 1);
    check_eq("t5_pkts_gap", pkt_count, 0);
    push(8'h00, 64'h13); push(8'h06, 64'h14);
    drain(20);
    check_eq("t5_pkts", pkt_count, 1);

    // reset mid-payload with FIFO non-empty
    do_reset();
    push(8'h60, 64'h20); push(8'h00, 64'h21); push(8'h00, 64'h22);
    push(8'h00, 64'h23); push(8'h07, 64'h24);
    cycle(); cycle();
    do_reset();
    check_eq("t6_fifo_left", fifo_q.size(), 3);
    cycle();
    check_eq("t6_new_pkt", in_pkt, 1);
    drain(20);
    check_eq("t6_pkts", pkt_count, 1);
    check_eq("t6_words", word_count, 3);

    // randomized soak
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (pend_q.size() == 0) gen_packet();
      if ($urandom_range(0, 9) < 7) fifo_q.push_back(pend_q.pop_front());
      tb_rdy = ($urandom_range(0, 3) != 0);
      tb_en  = ($urandom_range(0, 7) != 0);
      tb_rst = ($urandom_range(0, 599) == 0);
      cycle();
    end
    tb_rst = 0; tb_en = 1; tb_rdy = 1;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_drain.md
Name: pkt_fifo_drain

Overview:
- Packet-aware drain stage directly downstream of a 72-bit first-word-fallthrough small FIFO.
- Pops words as {ctrl[7:0], data[63:0]} and forwards them onto the standard out_data/out_ctrl/out_wr/out_rdy module interface.
- Tracks packet boundaries: module-header words (ctrl!=0), then payload (ctrl==0), then end-of-packet word (ctrl!=0 after payload).
- Supports clean stop at packet boundaries via enable, and provides packet/word statistics plus an oversize-packet error flag.

Parameters:
- DATA_WIDTH, 64, data field width.
- CTRL_WIDTH, 8, ctrl field width; the FIFO word is {ctrl, data}, ctrl in the MSBs.
- COUNT_WIDTH, 32, width of the statistics counters.
- MAX_PKT_WORDS, 256, payload-plus-EOP word limit per packet before oversize_err.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_fifo_dout  in  CTRL_WIDTH+DATA_WIDTH  FIFO head word; valid whenever !in_fifo_empty.
- in_fifo_empty  in  1  FIFO empty.
- in_fifo_rd_en  out  1  pop head word (combinational).
- out_data  out  DATA_WIDTH  registered data.
- out_ctrl  out  CTRL_WIDTH  registered ctrl.
- out_wr  out  1  registered write strobe.
- out_rdy  in  1  downstream may accept a word next cycle; downstream deasserts it one word early (nearly-full style).
- enable  in  1  permit starting a new packet.
- in_pkt  out  1  state != IDLE.
- pkt_count  out  COUNT_WIDTH  completed packets.
- word_count  out  COUNT_WIDTH  words popped.
- oversize_err  out  1  sticky oversize flag.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on reset; all state is cleared on a clk edge with reset=1.
- Reset values:
  - state=IDLE.
  - out_wr=0; out_data=0; out_ctrl=0.
  - pkt_count=0; word_count=0; oversize_err=0.
  - Internal payload counter pw=0.
  - in_pkt=0.
  - in_fifo_rd_en=0 while reset=1.
- Pop rule (combinational): in_fifo_rd_en = !reset & !in_fifo_empty & out_rdy & (state!=IDLE | enable).
- Output: on each pop, out_data/out_ctrl <= in_fifo_dout fields and out_wr <= 1 on the next edge. Otherwise out_wr <= 0 and out_data/out_ctrl hold. Latency is 1 cycle from pop to out_wr. Back-to-back pops give continuous out_wr.
- FSM transitions are evaluated only on a pop; with ctrl = in_fifo_dout[71:64]:
  - IDLE: ctrl!=0 -> HDR; ctrl==0 -> PAYLOAD with pw=1.
  - HDR: ctrl!=0 -> stay HDR; ctrl==0 -> PAYLOAD with pw=1.
  - PAYLOAD: ctrl==0 -> stay, pw++; ctrl!=0 (EOP) -> IDLE, pkt_count++, pw=0.
- enable:
  - Sampled only in IDLE.
  - Deassertion mid-packet does not stall; the current packet drains completely, then the block holds in IDLE.
  - Reassertion resumes pops on the same cycle (rd_en is combinational).
- out_rdy low: no pop, FSM and counters hold. No word is lost or duplicated.
- word_count increments by 1 on every pop.
- Counter wrap:
  - pkt_count and word_count wrap modulo 2^COUNT_WIDTH.
  - pw saturates at MAX_PKT_WORDS.
- oversize_err:
  - Set when a pop in PAYLOAD occurs with pw==MAX_PKT_WORDS; the EOP word counts toward the limit.
  - Sticky until reset.
  - Forwarding continues unaffected.
- Empty FIFO: no pop; the FSM waits in its current state indefinitely. A packet may span FIFO-empty gaps.
- Simultaneous enable rise and FIFO non-empty in IDLE: pop on that cycle.
- Reset mid-packet:
  - State returns to IDLE.
  - Any word popped on the reset cycle is not forwarded (rd_en=0 during reset).
  - Residual FIFO words after reset are treated as a new packet start.

Test Plan:
- Reset, then FIFO holds 3 words: {0xFF,H}, {0x00,D0}, {0x01,D1}; enable=1, out_rdy=1. Required: out_wr high for 3 consecutive cycles, starting 1 cycle after first rd_en, data H/D0/D1 in order; pkt_count=1; word_count=3; in_pkt back to 0.
- Same packet with out_rdy toggling 1,0,1,0,... Required: exactly 3 out_wr pulses, each one cycle after out_rdy=1 with non-empty FIFO; no duplicates; pkt_count=1.
- enable dropped after the header word of a 4-word packet, with a second packet queued. Required: first packet fully forwarded; second not popped (in_fifo_rd_en=0, in_pkt=0). enable=1 -> second packet drains; pkt_count=2.
- MAX_PKT_WORDS=4, packet with 1 header + 5 payload + EOP. Required: oversize_err rises on the 5th payload-phase pop; all 7 words forwarded; flag stays 1 after the packet and through later good packets; cleared only by reset.
- FIFO empties mid-payload for 10 cycles, then the remainder arrives. Required: in_pkt stays 1, no out_wr during the gap, pkt_count increments only at EOP.
- reset asserted for 1 cycle mid-payload with FIFO non-empty. Required: no pop on the reset cycle; the next cycle has out_wr=0; counters=0; state=IDLE; next popped word starts a new packet.
